// File: rtl/ram_sp_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ram_sp_arbiter: one single-port RAM shared by fetch and load/store ports.     |
// | Revision: 1.0                                                                 |
// +-----------------------------------------------------------------------------+
module ram_sp_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int RAM_AW       = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ifu_req,
    input  logic [AW-1:0]     ifu_addr,
    output logic              ifu_gnt,
    output logic              ifu_rvalid,
    output logic [DW-1:0]     ifu_rdata,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [3:0]        lsu_be,
    input  logic [AW-1:0]     lsu_addr,
    input  logic [DW-1:0]     lsu_wdata,
    output logic              lsu_gnt,
    output logic              lsu_rvalid,
    output logic [DW-1:0]     lsu_rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     ram_wdata,
    input  logic [DW-1:0]     ram_rdata
);

    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_IFU    = 2'd1,
        OWN_LSU_RD = 2'd2,
        OWN_LSU_WR = 2'd3
    } owner_t;

    owner_t        resp_owner;
    logic [CW-1:0] starve_cnt;
    logic          force_ifu;
    logic          unused_addr_bits;

    // Fetch overrides the LSU only once it has been denied STARVE_LIMIT cycles in a row.
    assign force_ifu = ifu_req && (starve_cnt >= LIMIT);
    assign lsu_gnt   = lsu_req && !force_ifu;
    assign ifu_gnt   = ifu_req && !lsu_gnt;

    assign ram_en    = ifu_gnt | lsu_gnt;
    assign ram_we    = (lsu_gnt && lsu_we) ? lsu_be : 4'b0000;
    assign ram_addr  = lsu_gnt ? lsu_addr[RAM_AW+1:2] : ifu_addr[RAM_AW+1:2];
    assign ram_wdata = lsu_wdata;

    assign unused_addr_bits = ^{ifu_addr[AW-1:RAM_AW+2], ifu_addr[1:0],
                                lsu_addr[AW-1:RAM_AW+2], lsu_addr[1:0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_owner <= OWN_NONE;
            ifu_rvalid <= 1'b0;
            lsu_rvalid <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (lsu_gnt) begin
                resp_owner <= lsu_we ? OWN_LSU_WR : OWN_LSU_RD;
            end else if (ifu_gnt) begin
                resp_owner <= OWN_IFU;
            end else begin
                resp_owner <= OWN_NONE;
            end
            ifu_rvalid <= ifu_gnt;
            lsu_rvalid <= lsu_gnt;

            if (!ifu_req || ifu_gnt) begin
                starve_cnt <= '0;
            end else if (starve_cnt < LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // RAM data is live in the response cycle; steer it to the owner, zero elsewhere.
    assign ifu_rdata = (resp_owner == OWN_IFU)    ? ram_rdata : '0;
    assign lsu_rdata = (resp_owner == OWN_LSU_RD) ? ram_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_sp_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_ram_sp_arbiter: table vectors, corner sequences and random traffic.        |
// | Revision: 1.0                                                                 |
// +-----------------------------------------------------------------------------+
module tb_ram_sp_arbiter;

    localparam int AW           = 32;
    localparam int DW           = 32;
    localparam int RAM_AW       = 10;
    localparam int STARVE_LIMIT = 4;
    localparam int DEPTH        = 1 << RAM_AW;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              ifu_req, ifu_gnt, ifu_rvalid;
    logic [AW-1:0]     ifu_addr;
    logic [DW-1:0]     ifu_rdata;
    logic              lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
    logic [3:0]        lsu_be;
    logic [AW-1:0]     lsu_addr;
    logic [DW-1:0]     lsu_wdata, lsu_rdata;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [DW-1:0]     ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    ram_sp_arbiter #(
        .AW(AW), .DW(DW), .RAM_AW(RAM_AW), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_be(lsu_be), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
        .lsu_rdata(lsu_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    function automatic logic [31:0] init_val(input int i);
        case (i)
            0:       return 32'h0000_00A0;
            1:       return 32'h0000_00A1;
            2:       return 32'h0000_00A2;
            4:       return 32'h1122_3344;
            default: return 32'h5A5A_0000 ^ (32'(i) * 32'h0000_9E37);
        endcase
    endfunction

    // Block RAM environment: byte-strobed writes, one-cycle registered read.
    logic [31:0] mem [DEPTH];
    logic        ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
            ram_ready <= 1'b1;
        end else if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
        end
    end

    // Reference model: memory image, denied-fetch run length, pending response.
    logic [31:0] ref_mem [DEPTH];
    int          starve_run;
    int          exp_kind;     // 0 none, 1 fetch, 2 lsu
    logic [31:0] exp_data;

    int vectors;
    int miscompares;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    typedef struct {
        logic              ireq;
        logic [31:0]       iaddr;
        logic              lreq;
        logic              lwe;
        logic [3:0]        lbe;
        logic [31:0]       laddr;
        logic [31:0]       lwdata;
        logic              e_ig;
        logic              e_lg;
        logic [3:0]        e_we;
        logic [RAM_AW-1:0] e_addr;
        logic              e_irv;
        logic              e_lrv;
        logic [31:0]       e_rdata;
    } vec_t;

    function automatic vec_t mk(input logic ireq, input logic [31:0] iaddr,
                                input logic lreq, input logic lwe, input logic [3:0] lbe,
                                input logic [31:0] laddr, input logic [31:0] lwdata,
                                input logic e_ig, input logic e_lg, input logic [3:0] e_we,
                                input logic [RAM_AW-1:0] e_addr, input logic e_irv,
                                input logic e_lrv, input logic [31:0] e_rdata);
        vec_t v;
        v.ireq = ireq;  v.iaddr = iaddr;  v.lreq = lreq;  v.lwe = lwe;  v.lbe = lbe;
        v.laddr = laddr;  v.lwdata = lwdata;  v.e_ig = e_ig;  v.e_lg = e_lg;
        v.e_we = e_we;  v.e_addr = e_addr;  v.e_irv = e_irv;  v.e_lrv = e_lrv;
        v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic model_reset();
        starve_run = 0;
        exp_kind   = 0;
        exp_data   = '0;
    endtask

    // One cycle: drive at posedge+1, check grants at negedge, check response after edge.
    task automatic apply(input vec_t v, input bit use_tbl, output bit ig, output bit lg);
        int w;
        ifu_req = v.ireq;  ifu_addr = v.iaddr;
        lsu_req = v.lreq;  lsu_we = v.lwe;  lsu_be = v.lbe;
        lsu_addr = v.laddr;  lsu_wdata = v.lwdata;
        #4;
        lg = v.lreq && !(v.ireq && starve_run >= STARVE_LIMIT);
        ig = v.ireq && !lg;
        w  = lg ? word_of(v.laddr) : word_of(v.iaddr);
        chk("ifu_gnt", 32'(ifu_gnt), 32'(ig));
        chk("lsu_gnt", 32'(lsu_gnt), 32'(lg));
        chk("ram_en", 32'(ram_en), 32'(ig | lg));
        chk("ram_we", 32'(ram_we), (lg && v.lwe) ? 32'(v.lbe) : 32'd0);
        if (ig || lg) chk("ram_addr", 32'(ram_addr), 32'(w));
        if (use_tbl) begin
            chk("tbl_ifu_gnt", 32'(ifu_gnt), 32'(v.e_ig));
            chk("tbl_lsu_gnt", 32'(lsu_gnt), 32'(v.e_lg));
            chk("tbl_ram_we", 32'(ram_we), 32'(v.e_we));
            if (v.e_ig || v.e_lg) chk("tbl_ram_addr", 32'(ram_addr), 32'(v.e_addr));
        end

        if (lg && v.lwe) begin
            for (int b = 0; b < 4; b++)
                if (v.lbe[b]) ref_mem[w][8*b +: 8] = v.lwdata[8*b +: 8];
            exp_kind = 2;  exp_data = '0;
        end else if (lg) begin
            exp_kind = 2;  exp_data = ref_mem[w];
        end else if (ig) begin
            exp_kind = 1;  exp_data = ref_mem[w];
        end else begin
            exp_kind = 0;
        end
        starve_run = (v.ireq && !ig) ? starve_run + 1 : 0;

        @(posedge clk);
        #1;
        chk("ifu_rvalid", 32'(ifu_rvalid), 32'(exp_kind == 1));
        chk("lsu_rvalid", 32'(lsu_rvalid), 32'(exp_kind == 2));
        if (exp_kind == 1) chk("ifu_rdata", ifu_rdata, exp_data);
        if (exp_kind == 2) chk("lsu_rdata", lsu_rdata, exp_data);
        if (use_tbl) begin
            chk("tbl_ifu_rvalid", 32'(ifu_rvalid), 32'(v.e_irv));
            chk("tbl_lsu_rvalid", 32'(lsu_rvalid), 32'(v.e_lrv));
            if (v.e_irv) chk("tbl_ifu_rdata", ifu_rdata, v.e_rdata);
            if (v.e_lrv) chk("tbl_lsu_rdata", lsu_rdata, v.e_rdata);
        end
    endtask

    initial begin
        vec_t tbl[$];
        vec_t r;
        vec_t ld;
        bit   ig, lg, ihold, lhold;

        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        model_reset();

        // Fetch stream, 10-cycle conflict, store/load hazard, address wrap.
        tbl.push_back(mk(1, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'h0, 0, 1, 0, 32'hA0));
        tbl.push_back(mk(1, 32'h4, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'h0, 1, 1, 0, 32'hA1));
        tbl.push_back(mk(1, 32'h8, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'h0, 2, 1, 0, 32'hA2));
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9)
                tbl.push_back(mk(1, 32'h8, 1, 0, 4'hF, 32'h4, 32'h0, 1, 0, 4'h0, 2, 1, 0, 32'hA2));
            else
                tbl.push_back(mk(1, 32'h8, 1, 0, 4'hF, 32'h4, 32'h0, 0, 1, 4'h0, 1, 0, 1, 32'hA1));
        end
        tbl.push_back(mk(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 32'h0, 1, 1, 4'b0011, 32'h10, 32'hDEADBEEF,
                         0, 1, 4'b0011, 4, 0, 1, 32'h0));
        tbl.push_back(mk(0, 32'h0, 1, 0, 4'h0, 32'h10, 32'h0, 0, 1, 4'h0, 4, 0, 1, 32'h1122BEEF));
        tbl.push_back(mk(1, 32'h1000, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'h0, 0, 1, 0, 32'hA0));
        tbl.push_back(mk(0, 32'h0, 1, 0, 4'h0, 32'hFFFF_F002, 32'h0, 0, 1, 4'h0, 0, 0, 1, 32'hA0));
        tbl.push_back(mk(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 0, 0, 0, 32'h0));

        // Reset held with both requesters asking.
        ifu_req = 1;  ifu_addr = '0;
        lsu_req = 1;  lsu_we = 0;  lsu_be = '0;  lsu_addr = '0;  lsu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ifu_rvalid", 32'(ifu_rvalid), 32'd0);
        chk("rst_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
        chk("rst_ifu_rdata", ifu_rdata, 32'd0);
        chk("rst_lsu_rdata", lsu_rdata, 32'd0);
        ifu_req = 0;  lsu_req = 0;
        rstn = 1;

        foreach (tbl[i]) apply(tbl[i], 1'b1, ig, lg);

        // Reset lands between a fetch grant and its response.
        ifu_req = 1;  ifu_addr = 32'h4;  lsu_req = 0;
        #4;
        chk("mid_ifu_gnt", 32'(ifu_gnt), 32'd1);
        #2 rstn = 0;
        @(posedge clk);
        #1;
        chk("mid_ifu_rvalid", 32'(ifu_rvalid), 32'd0);
        ifu_req = 0;
        @(posedge clk);
        #1 rstn = 1;
        model_reset();

        // A valid load response must vanish as soon as reset asserts.
        ld = mk(0, 32'h0, 1, 0, 4'h0, 32'h8, 32'h0, 0, 1, 4'h0, 2, 0, 1, 32'hA2);
        apply(ld, 1'b1, ig, lg);
        lsu_req = 0;
        rstn = 0;
        #1;
        chk("async_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
        chk("async_lsu_rdata", lsu_rdata, 32'd0);
        @(posedge clk);
        #1 rstn = 1;
        model_reset();

        // Random traffic; an ungranted request is held with the same payload.
        ihold = 0;  lhold = 0;
        r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            if (!ihold) begin
                r.ireq  = ($urandom_range(0, 9) < 7);
                r.iaddr = $urandom_range(0, 1) ? $urandom : ($urandom & 32'hFFFF_003F);
            end
            if (!lhold) begin
                r.lreq   = ($urandom_range(0, 9) < 6);
                r.lwe    = 1'($urandom_range(0, 1));
                r.lbe    = 4'($urandom);
                r.laddr  = $urandom_range(0, 1) ? $urandom : ($urandom & 32'hFFFF_003F);
                r.lwdata = $urandom;
            end
            apply(r, 1'b0, ig, lg);
            ihold = r.ireq && !ig;
            lhold = r.lreq && !lg;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
